// File: rtl/flag_table_poller_pkg.sv
// Shared types for the flag table poller: FSM state encoding and ack-timeout counter sizing.
package flag_table_poller_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_EMIT      = 3'd4,
    ST_NEXT      = 3'd5
  } state_t;

  localparam int ACK_TIMEOUT_DFLT = 15;

  // Counter must be able to hold the value ACK_TIMEOUT itself.
  function automatic int ack_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/flag_table_poller.sv
// Scans a read-clear flag table one entry at a time and emits an event for each non-zero word.
// Event appears the cycle after the ack; evt_ready backpressure stalls the scan, so no read-clear data is lost.
module flag_table_poller
  import flag_table_poller_pkg::*;
#(
  parameter int INDEX_WIDTH = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DFLT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   table_init_done,
  input  logic                   table_non_zero,
  output logic                   rdreq_valid,
  output logic [INDEX_WIDTH-1:0] rdreq_index,
  input  logic                   rdack_valid,
  input  logic [DATA_WIDTH-1:0]  rdack_value,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [INDEX_WIDTH-1:0] evt_index,
  output logic [DATA_WIDTH-1:0]  evt_value,
  output logic                   scan_busy,
  output logic                   err_timeout
);

  localparam int CW = ack_cnt_width(ACK_TIMEOUT);
  localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]          CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0] IDX_LAST = '1;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] r_scan_idx;
  logic [CW-1:0]          ack_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_WAIT_INIT;
      r_scan_idx  <= '0;
      ack_cnt     <= '0;
      rdreq_valid <= 1'b0;
      rdreq_index <= '0;
      evt_valid   <= 1'b0;
      evt_index   <= '0;
      evt_value   <= '0;
      err_timeout <= 1'b0;
      scan_busy   <= 1'b0;
    end else begin
      rdreq_valid <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_WAIT_INIT: begin
          if (table_init_done) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (enable && table_non_zero) begin
            state       <= ST_REQ;
            rdreq_valid <= 1'b1;
            rdreq_index <= r_scan_idx;
            scan_busy   <= 1'b1;
          end
        end
        // Counter starts in the request cycle so it equals cycles-since-request.
        ST_REQ: begin
          state   <= ST_WAIT_ACK;
          ack_cnt <= ack_cnt + CNT_ONE;
        end
        ST_WAIT_ACK: begin
          ack_cnt <= ack_cnt + CNT_ONE;
          if (rdack_valid) begin
            if (rdack_value != '0) begin
              evt_valid <= 1'b1;
              evt_index <= r_scan_idx;
              evt_value <= rdack_value;
              state     <= ST_EMIT;
            end else begin
              state <= ST_NEXT;
            end
          end else if (ack_cnt == CNT_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_NEXT;
          end
        end
        ST_EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          ack_cnt    <= '0;
          r_scan_idx <= r_scan_idx + IDX_ONE;
          if (r_scan_idx == IDX_LAST || !enable) begin
            state     <= ST_IDLE;
            scan_busy <= 1'b0;
          end else begin
            state       <= ST_REQ;
            rdreq_valid <= 1'b1;
            rdreq_index <= r_scan_idx + IDX_ONE;
          end
        end
        default: begin
          state     <= ST_WAIT_INIT;
          ack_cnt   <= '0;
          evt_valid <= 1'b0;
          scan_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_table_poller.sv
// Bench for flag_table_poller: a read-clear table model answers requests; per-scenario tasks check against scan-order expectations.
module tb_flag_table_poller;

  localparam int IW = 4;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rstn, enable, table_init_done, table_non_zero;
  logic          rdreq_valid, rdack_valid, evt_valid, evt_ready, scan_busy, err_timeout;
  logic [IW-1:0] rdreq_index, evt_index;
  logic [DW-1:0] rdack_value, evt_value;

  flag_table_poller #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .table_init_done(table_init_done),
    .table_non_zero(table_non_zero), .rdreq_valid(rdreq_valid), .rdreq_index(rdreq_index),
    .rdack_valid(rdack_valid), .rdack_value(rdack_value), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_index(evt_index), .evt_value(evt_value),
    .scan_busy(scan_busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment: table contents and responder/consumer knobs
  logic [DW-1:0] mem [N];
  bit nz_force = 0, rand_delay = 0, rand_ready = 0, spurious = 0;
  int ack_delay = 3, noack_idx = -1, ready_block = 0;

  // Logs filled by the monitor
  int cyc = 0;
  int req_idx_q[$], req_cyc_q[$], evt_idx_q[$], err_cyc_q[$];
  logic [DW-1:0] evt_val_q[$];
  int evt_rise = 0, evt_acc = 0, last_ack_cyc = 0, evt_rises = 0, stab_viol = 0, req_during_evt = 0;

  initial begin
    bit nz, pend, prev_evt;
    int pend_idx, pend_cyc;
    logic [IW-1:0] held_idx;
    logic [DW-1:0] held_val;
    pend = 0; prev_evt = 0; pend_idx = 0; pend_cyc = 0; held_idx = '0; held_val = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    rdack_valid = 0; rdack_value = '0; evt_ready = 0; table_non_zero = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      nz = nz_force;
      for (int i = 0; i < N; i++) if (mem[i] != '0) nz = 1;
      table_non_zero = nz;
      if (!rstn) begin
        pend = 0; prev_evt = 0; rdack_valid = 0; rdack_value = '0; evt_ready = 0;
      end else begin
        if (rdreq_valid) begin
          req_idx_q.push_back(int'(rdreq_index));
          req_cyc_q.push_back(cyc);
          if (evt_valid) req_during_evt++;
          if (int'(rdreq_index) != noack_idx) begin
            pend = 1;
            pend_idx = int'(rdreq_index);
            pend_cyc = cyc + (rand_delay ? int'($urandom_range(1, TO - 1)) : ack_delay);
          end
        end
        rdack_valid = 0; rdack_value = '0;
        if (pend && cyc == pend_cyc) begin
          rdack_valid = 1;
          rdack_value = mem[pend_idx];
          if (mem[pend_idx] != '0) last_ack_cyc = cyc;
          mem[pend_idx] = '0;
          pend = 0;
        end else if (spurious) begin
          rdack_valid = 1;
          rdack_value = 32'hdead_beef;
        end
        if (evt_valid) begin
          if (!prev_evt) begin
            evt_rise = cyc; evt_rises++; held_idx = evt_index; held_val = evt_value;
          end else if (evt_index !== held_idx || evt_value !== held_val) begin
            stab_viol++;
          end
          evt_ready = (cyc - evt_rise >= ready_block) && (!rand_ready || $urandom_range(0, 1) == 1);
          if (evt_ready) begin
            evt_idx_q.push_back(int'(evt_index));
            evt_val_q.push_back(evt_value);
            evt_acc = cyc;
          end
        end else begin
          evt_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
        prev_evt = evt_valid && !evt_ready;
        if (err_timeout) err_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_logs();
    req_idx_q.delete(); req_cyc_q.delete(); evt_idx_q.delete(); evt_val_q.delete(); err_cyc_q.delete();
    evt_rises = 0; stab_viol = 0; req_during_evt = 0;
  endtask

  task automatic wait_req_idx(input int idx, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (req_idx_q.size() > 0 && req_idx_q[$] == idx) begin ok = 1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int quiet;
    ok = 0; quiet = 0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (req_idx_q.size() > 0 && scan_busy === 1'b0 && evt_valid === 1'b0) quiet++;
      else quiet = 0;
      if (quiet >= 4) begin ok = 1; break; end
    end
  endtask

  // Full scan starting at index 0 must request every entry once, in order.
  task automatic check_full_scan(input string name);
    bit seq_ok;
    seq_ok = (req_idx_q.size() == N);
    if (seq_ok) for (int i = 0; i < N; i++) if (req_idx_q[i] != i) seq_ok = 0;
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL %s_req_sequence got %0d requests (first %0d) exp indices 0..15 once each", name,
               req_idx_q.size(), req_idx_q.size() > 0 ? req_idx_q[0] : -1);
    end
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if ({rdreq_valid, evt_valid, err_timeout, scan_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {rdreq_valid, evt_valid, err_timeout, scan_busy});
    end
    checks++;
    if (rdreq_index !== '0 || evt_index !== '0 || evt_value !== '0) begin
      errors++;
      $display("FAIL reset_fields got rdreq_index %0d evt_index %0d evt_value %h exp 0", rdreq_index, evt_index, evt_value);
    end
  endtask

  task automatic test_init_gating();
    table_init_done = 0; enable = 1; nz_force = 1;
    rstn = 1;
    clear_logs();
    step(600);
    checks++;
    if (req_idx_q.size() != 0) begin
      errors++;
      $display("FAIL init_gating_rdreq got %0d requests exp 0", req_idx_q.size());
    end
    checks++;
    if (scan_busy !== 1'b0) begin
      errors++;
      $display("FAIL init_gating_busy got %b exp 0", scan_busy);
    end
    enable = 0; table_init_done = 1;
    step(4);
    nz_force = 0;
    checks++;
    if (scan_busy !== 1'b0 || req_idx_q.size() != 0) begin
      errors++;
      $display("FAIL init_idle_disabled got busy %b reqs %0d exp 0 0", scan_busy, req_idx_q.size());
    end
  endtask

  task automatic test_single_event();
    bit ok;
    clear_logs();
    mem[5] = 32'h0000_0081; ack_delay = 3;
    enable = 1;
    wait_idle(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_idle_wait got timeout exp idle"); end
    check_full_scan("single");
    checks++;
    if (evt_idx_q.size() != 1 || evt_idx_q[0] != 5 || evt_val_q[0] !== 32'h81) begin
      errors++;
      $display("FAIL single_event got %0d events (idx %0d val %h) exp 1 event idx 5 val 00000081", evt_idx_q.size(),
               evt_idx_q.size() > 0 ? evt_idx_q[0] : -1, evt_val_q.size() > 0 ? evt_val_q[0] : 32'h0);
    end
    checks++;
    if (evt_rise - last_ack_cyc != 1) begin
      errors++;
      $display("FAIL single_evt_latency got %0d cycles after ack exp 1", evt_rise - last_ack_cyc);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    mem[5] = 32'h0000_0081; ready_block = 50;
    wait_idle(2000, ok);
    ready_block = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_idle_wait got timeout exp idle"); end
    check_full_scan("bp");
    checks++;
    if (evt_idx_q.size() != 1 || evt_idx_q[0] != 5 || evt_val_q[0] !== 32'h81) begin
      errors++;
      $display("FAIL bp_event got %0d events exp 1 event idx 5 val 00000081", evt_idx_q.size());
    end
    checks++;
    if (evt_acc - evt_rise != 50) begin
      errors++;
      $display("FAIL bp_hold_cycles got %0d exp 50", evt_acc - evt_rise);
    end
    checks++;
    if (stab_viol != 0 || req_during_evt != 0) begin
      errors++;
      $display("FAIL bp_stability got %0d field changes %0d reqs while pending exp 0 0", stab_viol, req_during_evt);
    end
    checks++;
    if (req_cyc_q.size() < 7 || req_cyc_q[6] <= evt_acc) begin
      errors++;
      $display("FAIL bp_req_after_accept got req6 cycle %0d accept cycle %0d exp later", req_cyc_q.size() > 6 ? req_cyc_q[6] : -1, evt_acc);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    noack_idx = 7; nz_force = 1;
    wait_req_idx(15, 1000, ok);
    nz_force = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL to_req15_wait got timeout exp req 15"); end
    wait_idle(200, ok);
    noack_idx = -1;
    check_full_scan("to");
    checks++;
    if (err_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL to_err_count got %0d exp 1", err_cyc_q.size());
    end else begin
      checks++;
      if (req_cyc_q.size() < 8 || err_cyc_q[0] - req_cyc_q[7] != TO) begin
        errors++;
        $display("FAIL to_err_delay got %0d exp %0d", req_cyc_q.size() >= 8 ? err_cyc_q[0] - req_cyc_q[7] : -1, TO);
      end
    end
    checks++;
    if (req_idx_q.size() < 9 || req_idx_q[8] != 8) begin
      errors++;
      $display("FAIL to_next_index got %0d exp 8", req_idx_q.size() >= 9 ? req_idx_q[8] : -1);
    end
  endtask

  task automatic test_resume();
    bit ok;
    clear_logs();
    mem[9] = 32'h0000_0900; nz_force = 1; enable = 1;
    wait_req_idx(9, 500, ok);
    enable = 0;
    wait_idle(100, ok);
    checks++;
    if (!ok || req_idx_q.size() != 10 || scan_busy !== 1'b0) begin
      errors++;
      $display("FAIL resume_stop got %0d requests busy %b exp 10 requests busy 0", req_idx_q.size(), scan_busy);
    end
    checks++;
    if (evt_idx_q.size() != 1 || evt_idx_q[0] != 9 || evt_val_q[0] !== 32'h900) begin
      errors++;
      $display("FAIL resume_event got %0d events exp 1 event idx 9 val 00000900", evt_idx_q.size());
    end
    clear_logs();
    enable = 1;
    for (int i = 0; i < 50 && req_idx_q.size() == 0; i++) step(1);
    checks++;
    if (req_idx_q.size() == 0 || req_idx_q[0] != 10) begin
      errors++;
      $display("FAIL resume_index got %0d exp 10", req_idx_q.size() > 0 ? req_idx_q[0] : -1);
    end
    wait_req_idx(15, 500, ok);
    nz_force = 0;
    wait_idle(200, ok);
  endtask

  task automatic test_spurious();
    clear_logs();
    spurious = 1;
    step(10);
    spurious = 0;
    step(5);
    checks++;
    if (evt_rises != 0 || evt_valid !== 1'b0 || req_idx_q.size() != 0) begin
      errors++;
      $display("FAIL spurious_ack got %0d events %0d reqs exp 0 0", evt_rises, req_idx_q.size());
    end
  endtask

  task automatic test_random();
    bit ok, ev_ok;
    int exp_idx[$];
    logic [DW-1:0] exp_val[$];
    for (int it = 0; it < 3; it++) begin
      exp_idx.delete(); exp_val.delete();
      for (int i = 0; i < N; i++) mem[i] = ($urandom_range(0, 2) == 0) ? ($urandom() | 32'h1) : 32'h0;
      mem[$urandom_range(0, N - 1)] = $urandom() | 32'h100;
      for (int i = 0; i < N; i++) if (mem[i] != '0) begin exp_idx.push_back(i); exp_val.push_back(mem[i]); end
      clear_logs();
      rand_delay = 1; rand_ready = 1;
      wait_idle(3000, ok);
      rand_delay = 0; rand_ready = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL rand%0d_idle_wait got timeout exp idle", it); end
      check_full_scan("rand");
      ev_ok = (evt_idx_q.size() == exp_idx.size());
      if (ev_ok) for (int i = 0; i < exp_idx.size(); i++)
        if (evt_idx_q[i] != exp_idx[i] || evt_val_q[i] !== exp_val[i]) ev_ok = 0;
      checks++;
      if (!ev_ok) begin
        errors++;
        $display("FAIL rand%0d_events got %0d events exp %0d in index order", it, evt_idx_q.size(), exp_idx.size());
      end
      checks++;
      if (stab_viol != 0 || req_during_evt != 0 || err_cyc_q.size() != 0) begin
        errors++;
        $display("FAIL rand%0d_protocol got %0d changes %0d reqs %0d timeouts exp 0 0 0", it, stab_viol, req_during_evt, err_cyc_q.size());
      end
    end
  endtask

  task automatic test_reset_emit();
    bit ok;
    clear_logs();
    mem[3] = 32'h0000_0033; ready_block = 1000;
    for (int i = 0; i < 300 && evt_valid !== 1'b1; i++) step(1);
    checks++;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL rst_emit_reach got evt_valid %b exp 1", evt_valid); end
    rstn = 0;
    step(2);
    rstn = 1;
    ready_block = 0;
    step(1);
    checks++;
    if (evt_valid !== 1'b0 || scan_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit_clear got evt_valid %b busy %b exp 0 0", evt_valid, scan_busy);
    end
    clear_logs();
    nz_force = 1;
    for (int i = 0; i < 50 && req_idx_q.size() == 0; i++) step(1);
    checks++;
    if (req_idx_q.size() == 0 || req_idx_q[0] != 0) begin
      errors++;
      $display("FAIL rst_emit_restart got %0d exp 0", req_idx_q.size() > 0 ? req_idx_q[0] : -1);
    end
    wait_req_idx(15, 500, ok);
    nz_force = 0;
    wait_idle(200, ok);
    checks++;
    if (evt_idx_q.size() != 0) begin
      errors++;
      $display("FAIL rst_emit_discard got %0d events exp 0", evt_idx_q.size());
    end
  endtask

  initial begin
    rstn = 0; enable = 0; table_init_done = 0;
    step(2);
    test_reset();
    test_init_gating();
    test_single_event();
    test_backpressure();
    test_timeout();
    test_resume();
    test_spurious();
    test_random();
    test_reset_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
